// File: rtl/write_request_queue_pkg.sv
// Register-file geometry shared by the write request queue, the write-decode
// stage and the register file, plus the default queue depth.
package write_request_queue_pkg;

  localparam int REG_ADDR_WIDTH = 3;
  localparam int REG_COUNT      = 8;
  localparam int REG_DATA_WIDTH = 32;
  localparam int QUEUE_DEPTH    = 4;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] data;
  } reg_write_t;

endpackage

// File: rtl/write_request_queue_mem.sv
// Queue storage: DEPTH entries of {addr,data}, synchronous write, asynchronous
// read at the head pointer.
module write_queue_mem
  import write_request_queue_pkg::*;
#(
  parameter int DEPTH      = QUEUE_DEPTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [DEPTH-1:0][ENTRY_W-1:0] mem_d;
  logic [DEPTH-1:0][ENTRY_W-1:0] mem_q;

  // Next storage contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = {wr_addr, wr_data};
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage is cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign {rd_addr, rd_data} = mem_q[rd_ptr];

endmodule

// File: rtl/write_request_queue.sv
// FIFO of register-file write requests: valid/ready on the producer side, one
// issue per cycle to the write-decode stage unless held or flushed.
module write_request_queue
  import write_request_queue_pkg::*;
#(
  parameter int DEPTH      = QUEUE_DEPTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign count   = count_q;
  assign s_ready = !full;
  assign m_we    = !empty && !hold && !flush;

  // A flush swallows any push offered in the same cycle.
  assign push_s  = s_valid && s_ready && !flush;
  assign pop_s   = m_we;

  // Pointer and occupancy update; flush returns everything to the origin.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Queue control state; reset dominates flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  write_queue_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_s),
    .wr_ptr  (wr_ptr_q),
    .wr_addr (s_addr),
    .wr_data (s_data),
    .rd_ptr  (rd_ptr_q),
    .rd_addr (m_addr),
    .rd_data (m_data)
  );

endmodule

// File: tb/tb_write_request_queue.sv
// Bench for write_request_queue: hand-derived vector table for reset, single
// write, fill/drain, flush, reset and hold corners, then random traffic vs a queue model.
module tb_write_request_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [2:0]  s_addr = 3'd0;
  logic [31:0] s_data = 32'd0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        m_we;
  logic [2:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  write_request_queue dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .hold(hold), .flush(flush),
    .m_we(m_we), .m_addr(m_addr), .m_data(m_data), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst_n;
    bit          v;
    logic [2:0]  a;
    logic [31:0] d;
    bit          h;
    bit          f;
    int          cnt;
    bit          we;
    bit          cad;
    logic [2:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];
  logic [34:0] mq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic vec_t mk(bit chk, bit rst_n, bit v, logic [2:0] a, logic [31:0] d,
                              bit h, bit f, int cnt, bit we, bit cad,
                              logic [2:0] ea, logic [31:0] ed);
    vec_t r;
    r.chk = chk; r.rst_n = rst_n; r.v = v; r.a = a; r.d = d; r.h = h; r.f = f;
    r.cnt = cnt; r.we = we; r.cad = cad; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rst_n, input bit v, input logic [2:0] a,
                       input logic [31:0] d, input bit h, input bit f);
    @(negedge clk);
    cyc++;
    reset_n = rst_n; s_valid = v; s_addr = a; s_data = d; hold = h; flush = f;
    #1;
  endtask

  // Reference behaviour at the coming edge, from the queue rules alone.
  task automatic model_update();
    int sz;
    sz = mq.size();
    if (!reset_n || flush) begin
      mq.delete();
    end else begin
      if (sz > 0 && !hold) void'(mq.pop_front());
      if (s_valid && sz < DEPTH) mq.push_back({s_addr, s_data});
    end
  endtask

  task automatic model_check();
    int sz;
    sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("s_ready", 64'(s_ready), 64'(sz < DEPTH));
    chk("m_we", 64'(m_we), 64'(sz > 0 && !hold && !flush));
    if (sz > 0) chk("head", 64'({m_addr, m_data}), 64'(mq[0]));
  endtask

  initial begin
    // reset with s_valid high
    tbl.push_back(mk(0, 0, 1, 3'd7, 32'h55, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 3'd7, 32'h55, 0, 0, 0, 0, 1, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 1, 3'd0, 32'h0));
    // single write, no bypass
    tbl.push_back(mk(1, 1, 1, 3'd3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 1, 1, 1, 3'd3, 32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    // fill under hold, fifth request waits
    tbl.push_back(mk(1, 1, 1, 3'd0, 32'h10, 1, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd1, 32'h11, 1, 0, 1, 0, 1, 3'd0, 32'h10));
    tbl.push_back(mk(1, 1, 1, 3'd2, 32'h12, 1, 0, 2, 0, 1, 3'd0, 32'h10));
    tbl.push_back(mk(1, 1, 1, 3'd3, 32'h13, 1, 0, 3, 0, 1, 3'd0, 32'h10));
    tbl.push_back(mk(1, 1, 1, 3'd4, 32'h14, 1, 0, 4, 0, 1, 3'd0, 32'h10));
    tbl.push_back(mk(1, 1, 1, 3'd4, 32'h14, 1, 0, 4, 0, 1, 3'd0, 32'h10));
    // drain: full pop refuses push, then push+pop keeps count
    tbl.push_back(mk(1, 1, 1, 3'd4, 32'h14, 0, 0, 4, 1, 1, 3'd0, 32'h10));
    tbl.push_back(mk(1, 1, 1, 3'd4, 32'h14, 0, 0, 3, 1, 1, 3'd1, 32'h11));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 3, 1, 1, 3'd2, 32'h12));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 2, 1, 1, 3'd3, 32'h13));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 1, 1, 1, 3'd4, 32'h14));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    // flush with a concurrent push
    tbl.push_back(mk(1, 1, 1, 3'd5, 32'h20, 1, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd6, 32'h21, 1, 0, 1, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd7, 32'h22, 1, 0, 2, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd1, 32'h99, 0, 1, 3, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd2, 32'h33, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 1, 1, 1, 3'd2, 32'h33));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    // reset mid-operation with a concurrent push
    tbl.push_back(mk(1, 1, 1, 3'd5, 32'h40, 1, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd6, 32'h41, 1, 0, 1, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd7, 32'h42, 1, 0, 2, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 3'd1, 32'h88, 1, 0, 3, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 1, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 1, 3'd0, 32'h0));
    // hold toggling with two queued entries
    tbl.push_back(mk(1, 1, 1, 3'd1, 32'h50, 0, 0, 0, 0, 0, 3'd0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 3'd2, 32'h51, 1, 0, 1, 0, 1, 3'd1, 32'h50));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 2, 1, 1, 3'd1, 32'h50));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 1, 0, 1, 0, 1, 3'd2, 32'h51));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 0, 0, 1, 1, 1, 3'd2, 32'h51));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0, 1, 0, 0, 0, 0, 3'd0, 32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].f);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].cnt));
        chk($sformatf("tbl%0d.full", i), 64'(full), 64'(tbl[i].cnt == DEPTH));
        chk($sformatf("tbl%0d.empty", i), 64'(empty), 64'(tbl[i].cnt == 0));
        chk($sformatf("tbl%0d.s_ready", i), 64'(s_ready), 64'(tbl[i].cnt != DEPTH));
        chk($sformatf("tbl%0d.m_we", i), 64'(m_we), 64'(tbl[i].we));
        if (tbl[i].cad) begin
          chk($sformatf("tbl%0d.m_addr", i), 64'(m_addr), 64'(tbl[i].ea));
          chk($sformatf("tbl%0d.m_data", i), 64'(m_data), 64'(tbl[i].ed));
        end
      end
      model_update();
    end

    // steady stream: one in, one out each cycle, pointers wrap several times
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1, 3'(i % 8), $urandom, 1'b0, 1'b0);
      model_check();
      if (i > 0) chk("steady_count", 64'(count), 64'd1);
      model_update();
    end

    // random traffic against the reference queue
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) >= 2), ($urandom_range(99) < 70), 3'($urandom),
            $urandom, ($urandom_range(99) < 35), ($urandom_range(99) < 3));
      model_check();
      model_update();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
